// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the counter command arbiter.
// Command codes, sequencer states, ASCII bytes, LED encodings and the UART byte decoder.
package counter_ctrl_pkg;

    typedef enum logic [2:0] {
        CMD_MODE_TOGGLE = 3'd0,
        CMD_RUN_TOGGLE  = 3'd1,
        CMD_RUN         = 3'd2,
        CMD_STOP        = 3'd3,
        CMD_CLEAR       = 3'd4
    } cmd_e;

    typedef enum logic [1:0] {
        STOP  = 2'd0,
        RUN   = 2'd1,
        CLEAR = 2'd2
    } seq_state_e;

    localparam int CMD_W = $bits(cmd_e);

    localparam logic [7:0] ASCII_M_UC = 8'h4D;
    localparam logic [7:0] ASCII_M_LC = 8'h6D;
    localparam logic [7:0] ASCII_R_UC = 8'h52;
    localparam logic [7:0] ASCII_R_LC = 8'h72;
    localparam logic [7:0] ASCII_S_UC = 8'h53;
    localparam logic [7:0] ASCII_S_LC = 8'h73;
    localparam logic [7:0] ASCII_C_UC = 8'h43;
    localparam logic [7:0] ASCII_C_LC = 8'h63;

    localparam logic [7:0] ECHO_U = 8'h55;
    localparam logic [7:0] ECHO_D = 8'h44;
    localparam logic [7:0] ECHO_R = 8'h52;
    localparam logic [7:0] ECHO_S = 8'h53;
    localparam logic [7:0] ECHO_C = 8'h43;
    localparam logic [7:0] ECHO_X = 8'h58;

    localparam logic [1:0] LED_UP      = 2'b01;
    localparam logic [1:0] LED_DOWN    = 2'b10;
    localparam logic [1:0] LED_STOPPED = 2'b01;
    localparam logic [1:0] LED_RUNNING = 2'b10;

    typedef struct packed {
        logic valid;
        cmd_e cmd;
    } cmd_req_t;

    function automatic cmd_req_t uart_decode(input logic [7:0] b);
        cmd_req_t r;
        r.valid = 1'b1;
        r.cmd   = CMD_MODE_TOGGLE;
        case (b)
            ASCII_M_UC, ASCII_M_LC: r.cmd = CMD_MODE_TOGGLE;
            ASCII_R_UC, ASCII_R_LC: r.cmd = CMD_RUN;
            ASCII_S_UC, ASCII_S_LC: r.cmd = CMD_STOP;
            ASCII_C_UC, ASCII_C_LC: r.cmd = CMD_CLEAR;
            default:                r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with exact occupancy count; DEPTH must be a power of two.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once count says they are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/counter_cmd_arbiter.sv
// Arbitrates button and UART commands into a FIFO and sequences STOP/RUN/CLEAR for the counter.
// Optional macro CMD_ECHO_EN adds a UART status-character echo (tx_busy/tx_start/tx_data).
//
// state | meaning
// STOP  | counter halted, commands popped and applied
// RUN   | counter and divider enabled, CMD_CLEAR is discarded
// CLEAR | clear held high for CLEAR_CYCLES cycles, FIFO pops stalled
module counter_cmd_arbiter
    import counter_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int CLEAR_CYCLES = 1,
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             btn_mode,
    input  logic             btn_run_stop,
    input  logic             btn_clear,
    input  logic [7:0]       rx_data,
    input  logic             rx_done,
`ifdef CMD_ECHO_EN
    input  logic             tx_busy,
    output logic             tx_start,
    output logic [7:0]       tx_data,
`endif
    output logic             mode,
    output logic             run_stop,
    output logic             clear,
    output logic [1:0]       led_mode,
    output logic [1:0]       led_run_stop,
    output logic             cmd_overflow,
    output logic [CNT_W-1:0] fifo_count
);

    localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
`ifdef CMD_ECHO_EN
    localparam int ENTRY_W = CMD_W + 1;
`else
    localparam int ENTRY_W = CMD_W;
`endif

    seq_state_e       state_q, state_d;
    logic             mode_q, mode_d;
    logic [CLR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic             skid_valid_q, skid_valid_d;
    cmd_e             skid_cmd_q, skid_cmd_d;
    logic             overflow_q, overflow_d;

    cmd_req_t         btn_req;
    cmd_req_t         uart_req;
    logic             push;
    cmd_e             push_cmd;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;
    cmd_e             head_cmd;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic             skid_drop;
`ifdef CMD_ECHO_EN
    logic             push_src_uart;
    logic             head_src_uart;
`endif

    always_comb begin
        btn_req.valid = btn_clear || btn_run_stop || btn_mode;
        if (btn_clear)         btn_req.cmd = CMD_CLEAR;
        else if (btn_run_stop) btn_req.cmd = CMD_RUN_TOGGLE;
        else                   btn_req.cmd = CMD_MODE_TOGGLE;

        uart_req = uart_decode(rx_data);
        if (!rx_done) uart_req.valid = 1'b0;
    end

    // The skid entry always drains on the cycle after capture, so only a
    // UART command arriving in that same cycle can find it occupied.
    always_comb begin
        push         = 1'b0;
        push_cmd     = CMD_MODE_TOGGLE;
        skid_valid_d = 1'b0;
        skid_cmd_d   = skid_cmd_q;
        skid_drop    = 1'b0;
`ifdef CMD_ECHO_EN
        push_src_uart = 1'b0;
`endif
        if (skid_valid_q) begin
            push      = 1'b1;
            push_cmd  = skid_cmd_q;
            skid_drop = uart_req.valid;
`ifdef CMD_ECHO_EN
            push_src_uart = 1'b1;
`endif
        end else if (btn_req.valid) begin
            push     = 1'b1;
            push_cmd = btn_req.cmd;
            if (uart_req.valid) begin
                skid_valid_d = 1'b1;
                skid_cmd_d   = uart_req.cmd;
            end
        end else if (uart_req.valid) begin
            push     = 1'b1;
            push_cmd = uart_req.cmd;
`ifdef CMD_ECHO_EN
            push_src_uart = 1'b1;
`endif
        end
        overflow_d = overflow_q || skid_drop || (push && fifo_full && !pop);
    end

`ifdef CMD_ECHO_EN
    assign push_entry    = {push_src_uart, push_cmd};
    assign head_src_uart = head_entry[CMD_W];
`else
    assign push_entry = push_cmd;
`endif
    assign head_cmd = cmd_e'(head_entry[CMD_W-1:0]);
    assign pop      = !fifo_empty && (state_q != CLEAR);

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_cmd_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .pop_data_o  (head_entry),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            STOP: begin
                if (pop) begin
                    case (head_cmd)
                        CMD_RUN, CMD_RUN_TOGGLE: state_d = RUN;
                        CMD_CLEAR: begin
                            state_d   = CLEAR;
                            clr_cnt_d = CLR_W'(CLEAR_CYCLES - 1);
                        end
                        CMD_MODE_TOGGLE: mode_d = ~mode_q;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (pop) begin
                    case (head_cmd)
                        CMD_STOP, CMD_RUN_TOGGLE: state_d = STOP;
                        CMD_MODE_TOGGLE:          mode_d  = ~mode_q;
                        default: ;
                    endcase
                end
            end
            CLEAR: begin
                if (clr_cnt_q == '0) state_d = STOP;
                else                 clr_cnt_d = clr_cnt_q - CLR_W'(1);
            end
            default: state_d = STOP;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= STOP;
            mode_q       <= 1'b0;
            clr_cnt_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_cmd_q   <= CMD_MODE_TOGGLE;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            clr_cnt_q    <= clr_cnt_d;
            skid_valid_q <= skid_valid_d;
            skid_cmd_q   <= skid_cmd_d;
            overflow_q   <= overflow_d;
        end
    end

    assign mode         = mode_q;
    assign run_stop     = (state_q == RUN);
    assign clear        = (state_q == CLEAR);
    assign led_mode     = mode_q ? LED_DOWN : LED_UP;
    assign led_run_stop = (state_q == RUN) ? LED_RUNNING : LED_STOPPED;
    assign cmd_overflow = overflow_q;

`ifdef CMD_ECHO_EN
    logic       echo_pend_q, echo_pend_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       echo_load;
    logic [7:0] echo_char;

    // A newer echo replaces an unsent one; tx_data holds until the handoff.
    always_comb begin
        echo_load = pop && head_src_uart;
        case (head_cmd)
            CMD_MODE_TOGGLE: echo_char = mode_d ? ECHO_D : ECHO_U;
            CMD_CLEAR:       echo_char = (state_q == STOP) ? ECHO_C : ECHO_X;
            default:         echo_char = (state_d == RUN) ? ECHO_R : ECHO_S;
        endcase
        tx_start    = echo_pend_q && !tx_busy;
        echo_pend_d = echo_pend_q && !tx_start;
        tx_data_d   = tx_data_q;
        if (echo_load) begin
            echo_pend_d = 1'b1;
            tx_data_d   = echo_char;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            echo_pend_q <= 1'b0;
            tx_data_q   <= 8'h00;
        end else begin
            echo_pend_q <= echo_pend_d;
            tx_data_q   <= tx_data_d;
        end
    end

    assign tx_data = tx_data_q;
`endif

endmodule
